// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: state codes, opcodes,
// instruction classes and the per-state control decode.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_ERR    = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    CLS_R = 3'd0,
    CLS_I = 3'd1,
    CLS_S = 3'd2,
    CLS_J = 3'd3,
    CLS_L = 3'd4
  } cls_t;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [6:0] OP_J = 7'b0011011;
  localparam logic [6:0] OP_L = 7'b0001011;

  typedef struct packed {
    logic imem_req;
    logic dmem_req;
    logic memw;
    logic regw;
    logic jalr;
    logic pc_wb;
    logic alusrc;
    logic alud;
    logic error;
  } ctrl_t;

  // Controls that depend only on the state being entered and the latched class.
  function automatic ctrl_t state_ctrl(input state_t s, input cls_t c,
                                       input logic alusrc, input logic alud);
    ctrl_t o;
    logic  data_ph;
    data_ph    = (s == ST_EXEC) || (s == ST_MEM) || (s == ST_WB);
    o.imem_req = (s == ST_FETCH);
    o.dmem_req = (s == ST_MEM);
    o.memw     = (s == ST_MEM) && (c == CLS_S);
    o.regw     = (s == ST_WB);
    o.jalr     = (s == ST_WB) && (c == CLS_J);
    o.pc_wb    = (s == ST_WB) && (c == CLS_J);
    o.alusrc   = data_ph ? alusrc : 1'b0;
    o.alud     = data_ph ? alud : 1'b0;
    o.error    = (s == ST_ERR);
    return o;
  endfunction

endpackage

// File: rtl/op_classify.sv
// Combinational instruction classifier: maps {op,funct3} to a class, a
// legality flag and the ALU source/destination selects.
module op_classify
  import ctrl_pkg::*;
(
  input  logic [6:0] i_op,
  input  logic [2:0] i_funct3,
  output logic [2:0] o_cls,
  output logic       o_legal,
  output logic       o_alu_src,
  output logic       o_alud
);

  // Decode table; anything not listed is illegal.
  always_comb begin
    o_cls     = CLS_R;
    o_legal   = 1'b0;
    o_alu_src = 1'b0;
    o_alud    = 1'b0;
    case (i_op)
      OP_R: begin
        o_cls = CLS_R;
        case (i_funct3)
          3'b000: begin
            o_legal = 1'b1;
            o_alud  = 1'b0;
          end
          3'b010, 3'b111, 3'b101: begin
            o_legal = 1'b1;
            o_alud  = 1'b1;
          end
          default: begin
            o_legal = 1'b0;
            o_alud  = 1'b0;
          end
        endcase
      end
      OP_I: begin
        o_cls     = CLS_I;
        o_alu_src = 1'b1;
        case (i_funct3)
          3'b000, 3'b010, 3'b111: o_legal = 1'b1;
          default:                o_legal = 1'b0;
        endcase
      end
      OP_S: begin
        o_cls     = CLS_S;
        o_alu_src = 1'b1;
        if (i_funct3 == 3'b010) begin
          o_legal = 1'b1;
        end else begin
          o_legal = 1'b0;
        end
      end
      OP_J: begin
        o_cls     = CLS_J;
        o_alu_src = 1'b1;
        o_legal   = 1'b1;
      end
      OP_L: begin
        o_cls     = CLS_L;
        o_alu_src = 1'b1;
        o_legal   = 1'b1;
      end
      default: begin
        o_cls   = CLS_R;
        o_legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle processor control FSM with memory-ack wait counter and a sticky
// error state reached on illegal instructions or memory timeouts.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       imem_ack,
  input  logic       dmem_ack,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegW,
  output logic       MemW,
  output logic       ALUSrc,
  output logic       ALUD,
  output logic       Jalr,
  output logic       error,
  output logic [2:0] state
);

  // Comparing against TIMEOUT-1 before incrementing keeps the 4-bit counter in range.
  localparam logic [3:0] TMO_LAST = 4'(MEM_TIMEOUT - 1);

  state_t     r_state;
  logic [3:0] r_cnt;
  cls_t       r_cls;
  logic       r_alusrc;
  logic       r_alud;
  ctrl_t      r_ctl;

  logic [2:0] w_cls_raw;
  cls_t       w_cls;
  logic       w_legal;
  logic       w_alusrc;
  logic       w_alud;
  logic       w_fetch_ack;

  op_classify u_classify (
    .i_op      (op),
    .i_funct3  (funct3),
    .o_cls     (w_cls_raw),
    .o_legal   (w_legal),
    .o_alu_src (w_alusrc),
    .o_alud    (w_alud)
  );

  assign w_cls       = cls_t'(w_cls_raw);
  assign w_fetch_ack = (r_state == ST_FETCH) && imem_ack;

  // State, wait counter, latched class and registered per-state controls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_FETCH;
      r_cnt    <= 4'd0;
      r_cls    <= CLS_R;
      r_alusrc <= 1'b0;
      r_alud   <= 1'b0;
      r_ctl    <= state_ctrl(ST_FETCH, CLS_R, 1'b0, 1'b0);
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (imem_ack) begin
            r_state <= ST_DECODE;
            r_ctl   <= state_ctrl(ST_DECODE, r_cls, r_alusrc, r_alud);
          end else if (r_cnt == TMO_LAST) begin
            r_state <= ST_ERR;
            r_ctl   <= state_ctrl(ST_ERR, r_cls, r_alusrc, r_alud);
          end else begin
            r_cnt   <= r_cnt + 4'd1;
            r_ctl   <= state_ctrl(ST_FETCH, r_cls, r_alusrc, r_alud);
          end
        end
        ST_DECODE: begin
          if (w_legal) begin
            r_state  <= ST_EXEC;
            r_cls    <= w_cls;
            r_alusrc <= w_alusrc;
            r_alud   <= w_alud;
            r_ctl    <= state_ctrl(ST_EXEC, w_cls, w_alusrc, w_alud);
          end else begin
            r_state  <= ST_ERR;
            r_ctl    <= state_ctrl(ST_ERR, r_cls, r_alusrc, r_alud);
          end
        end
        ST_EXEC: begin
          if ((r_cls == CLS_S) || (r_cls == CLS_L)) begin
            r_state <= ST_MEM;
            r_cnt   <= 4'd0;
            r_ctl   <= state_ctrl(ST_MEM, r_cls, r_alusrc, r_alud);
          end else begin
            r_state <= ST_WB;
            r_ctl   <= state_ctrl(ST_WB, r_cls, r_alusrc, r_alud);
          end
        end
        ST_MEM: begin
          if (dmem_ack) begin
            if (r_cls == CLS_S) begin
              r_state <= ST_FETCH;
              r_cnt   <= 4'd0;
              r_ctl   <= state_ctrl(ST_FETCH, r_cls, r_alusrc, r_alud);
            end else begin
              r_state <= ST_WB;
              r_ctl   <= state_ctrl(ST_WB, r_cls, r_alusrc, r_alud);
            end
          end else if (r_cnt == TMO_LAST) begin
            r_state <= ST_ERR;
            r_ctl   <= state_ctrl(ST_ERR, r_cls, r_alusrc, r_alud);
          end else begin
            r_cnt   <= r_cnt + 4'd1;
            r_ctl   <= state_ctrl(ST_MEM, r_cls, r_alusrc, r_alud);
          end
        end
        ST_WB: begin
          r_state <= ST_FETCH;
          r_cnt   <= 4'd0;
          r_ctl   <= state_ctrl(ST_FETCH, r_cls, r_alusrc, r_alud);
        end
        ST_ERR: begin
          r_state <= ST_ERR;
          r_ctl   <= state_ctrl(ST_ERR, r_cls, r_alusrc, r_alud);
        end
        default: begin
          r_state <= ST_ERR;
          r_ctl   <= state_ctrl(ST_ERR, r_cls, r_alusrc, r_alud);
        end
      endcase
    end
  end

  // IRWrite and the fetch half of PCWrite follow imem_ack in the same cycle.
  assign IRWrite  = w_fetch_ack;
  assign PCWrite  = w_fetch_ack | r_ctl.pc_wb;
  assign imem_req = r_ctl.imem_req;
  assign dmem_req = r_ctl.dmem_req;
  assign RegW     = r_ctl.regw;
  assign MemW     = r_ctl.memw;
  assign ALUSrc   = r_ctl.alusrc;
  assign ALUD     = r_ctl.alud;
  assign Jalr     = r_ctl.jalr;
  assign error    = r_ctl.error;
  assign state    = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench: builds an expected per-cycle trace from instruction-level
// rules (class, ack delays, timeouts, resets) and compares every cycle.
module tb_multicycle_ctrl;

  localparam int TMO = 15;
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [6:0] OP_J = 7'b0011011;
  localparam logic [6:0] OP_L = 7'b0001011;

  logic clk = 1'b0;
  logic rst, imem_ack, dmem_ack;
  logic [6:0] op;
  logic [2:0] funct3;
  logic imem_req, dmem_req, IRWrite, PCWrite, RegW, MemW, ALUSrc, ALUD, Jalr, error;
  logic [2:0] state;

  multicycle_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req), .dmem_req(dmem_req),
    .IRWrite(IRWrite), .PCWrite(PCWrite),
    .RegW(RegW), .MemW(MemW), .ALUSrc(ALUSrc), .ALUD(ALUD), .Jalr(Jalr),
    .error(error), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         rst;
    bit         ima;
    bit         dma;
    logic [6:0] op;
    logic [2:0] f3;
    logic [12:0] ex;
  } cyc_t;

  cyc_t q[$];
  int   n_total = 0;
  int   n_bad   = 0;
  bit   m_err   = 1'b0;
  logic [2:0] r_f3s [4] = '{3'd0, 3'd2, 3'd7, 3'd5};
  logic [2:0] i_f3s [3] = '{3'd0, 3'd2, 3'd7};

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected vector: {state, imem_req, dmem_req, IRWrite, PCWrite, RegW, MemW, ALUSrc, ALUD, Jalr, error}
  function automatic logic [12:0] ev(input int st, input bit imr, input bit dmr, input bit irw,
                                     input bit pcw, input bit rgw, input bit mw, input bit as,
                                     input bit ad, input bit jl, input bit er);
    return {3'(st), imr, dmr, irw, pcw, rgw, mw, as, ad, jl, er};
  endfunction

  // Class codes: 0 R, 1 I, 2 S, 3 J, 4 L, -1 illegal.
  function automatic int ref_class(input logic [6:0] o, input logic [2:0] f, output bit as, output bit ad);
    as = 1'b1;
    ad = 1'b0;
    if (o == OP_R && (f == 3'd0 || f == 3'd2 || f == 3'd7 || f == 3'd5)) begin
      as = 1'b0;
      ad = (f != 3'd0);
      return 0;
    end
    if (o == OP_I && (f == 3'd0 || f == 3'd2 || f == 3'd7)) return 1;
    if (o == OP_S && f == 3'd2) return 2;
    if (o == OP_J) return 3;
    if (o == OP_L) return 4;
    as = 1'b0;
    return -1;
  endfunction

  task automatic push(input bit r, input bit ima, input bit dma, input logic [6:0] o,
                      input logic [2:0] f, input logic [12:0] ex);
    cyc_t e;
    e.rst = r; e.ima = ima; e.dma = dma; e.op = o; e.f3 = f; e.ex = ex;
    q.push_back(e);
  endtask

  // One instruction: di/dd are idle cycles before each ack (>= TMO means timeout);
  // rst_mem >= 0 applies reset after that many idle MEM cycles.
  task automatic gen_instr(input logic [6:0] o, input logic [2:0] f, input int di,
                           input int dd, input int rst_mem);
    bit as, ad;
    int c;
    bit is_s, is_j;
    c = ref_class(o, f, as, ad);
    is_s = (c == 2);
    is_j = (c == 3);
    for (int k = 0; k < di && k < TMO; k++)
      push(1'b0, 1'b0, rb(), o, f, ev(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    if (di >= TMO) begin m_err = 1'b1; return; end
    push(1'b0, 1'b1, rb(), o, f, ev(0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    push(1'b0, rb(), rb(), o, f, ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    if (c < 0) begin m_err = 1'b1; return; end
    push(1'b0, rb(), rb(), o, f, ev(2, 0, 0, 0, 0, 0, 0, as, ad, 0, 0));
    if (c == 2 || c == 4) begin
      for (int k = 0; k < dd && k < TMO; k++) begin
        if (k == rst_mem) begin
          push(1'b1, rb(), 1'b1, o, f, ev(3, 0, 1, 0, 0, 0, is_s, as, ad, 0, 0));
          return;
        end
        push(1'b0, rb(), 1'b0, o, f, ev(3, 0, 1, 0, 0, 0, is_s, as, ad, 0, 0));
      end
      if (dd >= TMO) begin m_err = 1'b1; return; end
      push(1'b0, rb(), 1'b1, o, f, ev(3, 0, 1, 0, 0, 0, is_s, as, ad, 0, 0));
      if (is_s) return;
    end
    push(1'b0, rb(), rb(), o, f, ev(4, 0, 0, 0, is_j, 1, 0, as, ad, is_j, 0));
  endtask

  task automatic gen_err_reset();
    logic [6:0] o;
    o = 7'($urandom);
    for (int k = 0; k < 3; k++)
      push(1'b0, rb(), rb(), o, 3'd1, ev(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    push(1'b1, rb(), rb(), o, 3'd1, ev(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    m_err = 1'b0;
  endtask

  task automatic run_instr(input logic [6:0] o, input logic [2:0] f, input int di,
                           input int dd, input int rst_mem);
    gen_instr(o, f, di, dd, rst_mem);
    if (m_err) gen_err_reset();
  endtask

  task automatic pick(output logic [6:0] o, output logic [2:0] f);
    int s;
    s = int'($urandom_range(0, 9));
    f = 3'($urandom_range(0, 7));
    case (s)
      0, 1:    begin o = OP_R; f = r_f3s[$urandom_range(0, 3)]; end
      2, 3:    begin o = OP_I; f = i_f3s[$urandom_range(0, 2)]; end
      4:       begin o = OP_S; f = 3'd2; end
      5:       o = OP_J;
      6, 7:    o = OP_L;
      8:       o = OP_S;
      default: o = 7'($urandom);
    endcase
  endtask

  function automatic int rdelay();
    if ($urandom_range(0, 15) == 0) return 14 + int'($urandom_range(0, 1));
    return int'($urandom_range(0, 3));
  endfunction

  initial begin
    logic [6:0] o;
    logic [2:0] f;
    int di, dd, rm;
    logic [12:0] got;
    rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; op = 7'd0; funct3 = 3'd0;
    repeat (2) @(posedge clk);

    run_instr(OP_R, 3'd0, 0, 0, -1);
    run_instr(OP_L, 3'd1, 0, 3, -1);
    run_instr(OP_S, 3'd2, 1, 2, -1);
    run_instr(OP_R, 3'd1, 0, 0, -1);
    run_instr(OP_I, 3'd0, 15, 0, -1);
    run_instr(OP_I, 3'd0, 14, 0, -1);
    run_instr(OP_J, 3'd5, 0, 0, -1);
    run_instr(OP_S, 3'd2, 0, 6, 2);
    push(1'b0, 1'b0, 1'b1, OP_R, 3'd0, ev(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    run_instr(OP_L, 3'd0, 0, 15, -1);
    run_instr(OP_L, 3'd0, 0, 14, -1);
    run_instr(OP_R, 3'd5, 2, 0, -1);
    for (int n = 0; n < 80; n++) begin
      pick(o, f);
      di = rdelay();
      dd = rdelay();
      rm = -1;
      if ($urandom_range(0, 9) == 0 && dd > 1 && dd < TMO) rm = int'($urandom_range(0, dd - 1));
      run_instr(o, f, di, dd, rm);
    end

    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      rst      = q[i].rst;
      imem_ack = q[i].ima;
      dmem_ack = q[i].dma;
      op       = q[i].op;
      funct3   = q[i].f3;
      #1;
      got = {state, imem_req, dmem_req, IRWrite, PCWrite, RegW, MemW, ALUSrc, ALUD, Jalr, error};
      chk_eq($sformatf("cyc%0d", i), 32'(got), 32'(q[i].ex));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, max cycles a memory request waits for ack (1..15).
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port op  input  7  opcode from instruction register.
REQ-005 SHALL have port funct3  input  3  funct3 from instruction register.
REQ-006 SHALL have port imem_ack  input  1  instruction memory data valid.
REQ-007 SHALL have port dmem_ack  input  1  data memory access complete.
REQ-008 SHALL have output ports imem_req and dmem_req  1 each  memory requests.
REQ-009 SHALL have output ports IRWrite and PCWrite  1 each  register enables.
REQ-010 SHALL have output ports RegW, MemW, ALUSrc, ALUD and Jalr  1 each  datapath controls.
REQ-011 SHALL have output port error  1  sticky fault flag.
REQ-012 SHALL have output port state  3  current state code.

Function
REQ-013 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4 and ERR=7; codes 5 and 6 SHALL go to ERR.
REQ-014 FETCH SHALL assert imem_req; on imem_ack it SHALL pulse IRWrite and PCWrite for that cycle and go to DECODE.
REQ-015 DECODE SHALL classify {op,funct3} and register the class plus ALUSrc/ALUD, held from EXEC through WB:
- R (0110011, f3 000/010/111/101): ALUSrc=0; ALUD=0 for f3 000, else 1.
- I (0010011, f3 000/010/111): ALUSrc=1, ALUD=0.
- S (0100011, f3 010): ALUSrc=1, ALUD=0.
- J (0011011, any f3): ALUSrc=1, ALUD=0.
- L (0001011, any f3): ALUSrc=1, ALUD=0.
REQ-016 Any other {op,funct3} SHALL send DECODE to ERR.
REQ-017 EXEC SHALL last one cycle, then go to MEM for S/L and to WB for R/I/J.
REQ-018 MEM SHALL assert dmem_req, and also MemW for S, until dmem_ack; on ack S SHALL go to FETCH and L to WB.
REQ-019 WB SHALL assert RegW for one cycle, then go to FETCH; for J it SHALL also assert Jalr and PCWrite.
REQ-020 Latency from FETCH entry to the next FETCH entry, with same-cycle acks, SHALL be: R/I/J 4, S 4, L 5 cycles.
REQ-021 Ack timing:
- An ack in the same cycle as its req SHALL be accepted.
- An ack arriving while its req is low SHALL be ignored.
- Simultaneous imem_ack and dmem_ack SHALL be resolved by state alone.
REQ-022 A 4-bit wait counter SHALL:
- clear on entry to FETCH or MEM;
- increment each cycle the ack is absent;
- go to ERR when the count equals MEM_TIMEOUT with the ack still low.
REQ-023 An ack in the cycle the count reaches MEM_TIMEOUT SHALL win over the timeout.
REQ-024 ERR SHALL drive all controls and requests to 0 and error=1, and SHALL stay there until rst.
REQ-025 Only IRWrite, PCWrite, RegW, MemW and Jalr SHALL be asserted per state as above; they SHALL be 0 in all other states.

Reset
REQ-026 rst=1 at a clock edge SHALL force FETCH, counter=0, class=R, error=0, and all outputs 0 except imem_req, which SHALL be 1 in FETCH.
REQ-027 rst SHALL override every state, including mid-MEM with MemW high, and the next cycle SHALL be FETCH with MemW=0.
REQ-028 rst SHALL take priority over a simultaneous ack.

Structure
REQ-029 Package ctrl_pkg SHALL hold the state codes, the opcode constants and the class encoding.
REQ-030 Sub-module op_classify (combinational: op, funct3 -> class, legal, ALUSrc, ALUD) SHALL be instantiated once; the FSM and counter SHALL live in multicycle_ctrl.

Verification
REQ-031 R add: op=0110011, f3=000, acks tied 1 -> states 0,1,2,4,0; RegW high in cycle 4; ALUD=0.
REQ-032 Load: op=0001011, dmem_ack delayed 3 cycles -> dmem_req held 4 cycles, MemW=0, then WB with RegW=1; 8 cycles total.
REQ-033 Store: op=0100011, f3=010 -> MemW=dmem_req=1 in MEM, RegW never 1, next state FETCH.
REQ-034 Illegal: op=0110011, f3=001 -> ERR after DECODE, error=1 sticky; rst -> state 0, error=0.
REQ-035 Timeout: MEM_TIMEOUT=15, imem_ack low -> ERR after 15 FETCH cycles; ack on cycle 15 instead -> DECODE.
REQ-036 Reset mid-MEM during a store -> next cycle state=0, MemW=0, dmem_req=0; a stray dmem_ack in FETCH is ignored.
